// File: rtl/lcd_write_arbiter.sv
// lcd_write_arbiter: two-port write arbiter driving an HD44780-style LCD bus.
// Each accepted byte is presented on lcd_data/lcd_rs, strobed with lcd_e and
// followed by a hold period before the next byte can be accepted.
// Ports:
//   clk, rst (async active-low)
//   r0_valid/r0_data/r0_rs/r0_ready : init sequencer request port
//   r1_valid/r1_data/r1_rs/r1_ready : CPU display-update request port
//   lcd_data, lcd_rs, lcd_rw, lcd_e  : LCD bus (write only)
//   busy, last_grant                 : status
// Config macro: LCD_ARB_RR_EN selects round-robin arbitration; fixed priority
// (port 0 wins) when undefined.
module lcd_write_arbiter #(
  parameter int unsigned SETUP_CYC     = 2,
  parameter int unsigned E_CYC         = 25,
  parameter int unsigned WAIT_CYC      = 2500,
  parameter int unsigned LONG_WAIT_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       r0_valid,
  input  logic [7:0] r0_data,
  input  logic       r0_rs,
  output logic       r0_ready,
  input  logic       r1_valid,
  input  logic [7:0] r1_data,
  input  logic       r1_rs,
  output logic       r1_ready,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic       busy,
  output logic       last_grant
);

  localparam int unsigned MAX_A   = (SETUP_CYC > E_CYC) ? SETUP_CYC : E_CYC;
  localparam int unsigned MAX_B   = (WAIT_CYC > LONG_WAIT_CYC) ? WAIT_CYC : LONG_WAIT_CYC;
  localparam int unsigned MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CNT_W   = ($clog2(MAX_CYC + 1) > 17) ? $clog2(MAX_CYC + 1) : 17;

  typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         data_q, data_d;
  logic               rs_q, rs_d;
  logic               last_grant_q, last_grant_d;
  logic               grant_c;
  logic               idle_c;
  logic               long_hold_c;

  // Arbitration: which port would be served if it is valid this cycle.
  always_comb begin
`ifdef LCD_ARB_RR_EN
    if (r0_valid && r1_valid) grant_c = ~last_grant_q;
    else                      grant_c = r1_valid;
`else
    grant_c = ~r0_valid;
`endif
  end

  // Ready is suppressed while reset is asserted even though state is IDLE.
  assign idle_c   = (state_q == IDLE) && rst;
  assign r0_ready = idle_c && !grant_c && r0_valid;
  assign r1_ready = idle_c &&  grant_c && r1_valid;

  // Clear display (0x01) and return home (0x02/0x03) need the long hold.
  assign long_hold_c = !rs_q && (data_q[7:2] == 6'd0) && (data_q != 8'd0);

  // Next-state and datapath.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    data_d       = data_q;
    rs_d         = rs_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (r0_ready || r1_ready) begin
          data_d       = grant_c ? r1_data : r0_data;
          rs_d         = grant_c ? r1_rs   : r0_rs;
          last_grant_d = grant_c;
          cnt_d        = CNT_W'(SETUP_CYC - 1);
          state_d      = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          cnt_d   = CNT_W'(E_CYC - 1);
          state_d = PULSE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      PULSE: begin
        if (cnt_q == '0) begin
          cnt_d   = long_hold_c ? CNT_W'(LONG_WAIT_CYC - 1) : CNT_W'(WAIT_CYC - 1);
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HOLD: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      data_q       <= 8'h00;
      rs_q         <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      data_q       <= data_d;
      rs_q         <= rs_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign lcd_data   = data_q;
  assign lcd_rs     = rs_q;
  assign lcd_rw     = 1'b0;
  assign lcd_e      = (state_q == PULSE);
  assign busy       = (state_q != IDLE);
  assign last_grant = last_grant_q;

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Directed bench for lcd_write_arbiter with short timing parameters
// (SETUP 2, E 4, WAIT 10, LONG_WAIT 40). Occupancy is counted from the
// transfer cycle to the first cycle back in IDLE.
module tb_lcd_write_arbiter;

  logic       clk;
  logic       rst;
  logic       r0_valid, r0_rs, r0_ready;
  logic [7:0] r0_data;
  logic       r1_valid, r1_rs, r1_ready;
  logic [7:0] r1_data;
  logic [7:0] lcd_data;
  logic       lcd_rs, lcd_rw, lcd_e, busy, last_grant;

  int checks = 0;
  int errors = 0;

  lcd_write_arbiter #(
    .SETUP_CYC(2), .E_CYC(4), .WAIT_CYC(10), .LONG_WAIT_CYC(40)
  ) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_data(r0_data), .r0_rs(r0_rs), .r0_ready(r0_ready),
    .r1_valid(r1_valid), .r1_data(r1_data), .r1_rs(r1_rs), .r1_ready(r1_ready),
    .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e),
    .busy(busy), .last_grant(last_grant)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Bus stability while busy, and lcd_rw always low.
  logic [7:0] prev_data;
  logic       prev_rs, prev_busy;
  initial prev_busy = 1'b0;
  always @(negedge clk) begin
    chk("lcd_rw_zero", 32'(lcd_rw), 0);
    if (rst && busy && prev_busy) begin
      chk("data_stable", 32'(lcd_data), 32'(prev_data));
      chk("rs_stable", 32'(lcd_rs), 32'(prev_rs));
    end
    prev_data = lcd_data;
    prev_rs   = lcd_rs;
    prev_busy = busy && rst;
  end

  // Issue one byte on a port and measure e start/length and occupancy.
  task automatic send(input bit port, input logic [7:0] d, input logic rs,
                      output int e_start, output int e_len, output int occ);
    bit got;
    @(posedge clk); #1;
    if (port) begin r1_valid = 1'b1; r1_data = d; r1_rs = rs; end
    else      begin r0_valid = 1'b1; r0_data = d; r0_rs = rs; end
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (port ? r1_ready : r0_ready) got = 1'b1;
    end
    chk("accepted", 32'(got), 1);
    @(posedge clk); #1;
    if (port) r1_valid = 1'b0; else r0_valid = 1'b0;
    e_start = -1; e_len = 0; occ = -1;
    for (int n = 1; n < 200; n++) begin
      @(negedge clk);
      if (lcd_e) begin
        if (e_start < 0) e_start = n;
        e_len++;
      end
      if (!busy) begin occ = n; break; end
    end
  endtask

  logic [7:0] tbl_d   [7] = '{8'h01, 8'h38, 8'h02, 8'h03, 8'h00, 8'h04, 8'h01};
  logic       tbl_rs  [7] = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b1};
  int         tbl_occ [7] = '{47,    17,    47,    47,    17,    17,    17};

  initial begin
    int es, el, oc;
    int gcnt, gcyc[4], gport[4];
    bit got, both, seen;
    rst = 1'b1;
    r0_valid = 1'b1; r0_data = 8'hAA; r0_rs = 1'b1;
    r1_valid = 1'b1; r1_data = 8'h55; r1_rs = 1'b1;
    #1 rst = 1'b0;
    #1;
    chk("rst_lcd_data", 32'(lcd_data), 0);
    chk("rst_lcd_rs", 32'(lcd_rs), 0);
    chk("rst_lcd_e", 32'(lcd_e), 0);
    chk("rst_lcd_rw", 32'(lcd_rw), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_last_grant", 32'(last_grant), 1);
    chk("rst_r0_ready", 32'(r0_ready), 0);
    chk("rst_r1_ready", 32'(r1_ready), 0);
    r0_valid = 1'b0; r1_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_held_busy", 32'(busy), 0);
    rst = 1'b1;

    // Single data byte from port 1.
    send(1'b1, 8'h41, 1'b1, es, el, oc);
    chk("single_e_start", 32'(es), 3);
    chk("single_e_len", 32'(el), 4);
    chk("single_occ", 32'(oc), 17);
    chk("single_data_idle", 32'(lcd_data), 32'h41);
    chk("single_rs_idle", 32'(lcd_rs), 1);
    chk("single_grant", 32'(last_grant), 1);

    // Port 0 commands: long vs normal hold boundaries.
    for (int i = 0; i < 7; i++) begin
      send(1'b0, tbl_d[i], tbl_rs[i], es, el, oc);
      chk($sformatf("cmd_%0h_rs%0d_occ", tbl_d[i], tbl_rs[i]), 32'(oc), 32'(tbl_occ[i]));
      chk("cmd_e_len", 32'(el), 4);
      chk("cmd_data_idle", 32'(lcd_data), 32'(tbl_d[i]));
      chk("cmd_grant", 32'(last_grant), 0);
    end

    // Withdrawn request on port 1 while a port 0 byte is in flight.
    @(posedge clk); #1;
    r0_valid = 1'b1; r0_data = 8'h38; r0_rs = 1'b0;
    @(negedge clk);
    chk("wd_r0_ready", 32'(r0_ready), 1);
    @(posedge clk); #1;
    r0_valid = 1'b0;
    r1_valid = 1'b1; r1_data = 8'h99; r1_rs = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (r1_ready) seen = 1'b1;
    end
    chk("wd_no_ready_busy", 32'(seen), 0);
    @(posedge clk); #1;
    r1_valid = 1'b0;
    for (int i = 0; i < 100 && busy; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("wd_busy", 32'(busy), 0);
    chk("wd_data_kept", 32'(lcd_data), 32'h38);
    chk("wd_grant", 32'(last_grant), 0);

    // Leave last_grant at 1 before contention.
    send(1'b1, 8'h2D, 1'b0, es, el, oc);
    chk("prep_occ", 32'(oc), 17);
    chk("prep_grant", 32'(last_grant), 1);

    // Contention: both ports valid continuously.
    @(posedge clk); #1;
    r0_valid = 1'b1; r0_data = 8'h38; r0_rs = 1'b0;
    r1_valid = 1'b1; r1_data = 8'h2D; r1_rs = 1'b0;
    gcnt = 0; both = 1'b0;
    for (int n = 0; n < 300 && gcnt < 4; n++) begin
      @(negedge clk);
      if (r0_ready && r1_ready) both = 1'b1;
      if (r0_ready || r1_ready) begin
        gcyc[gcnt]  = n;
        gport[gcnt] = r1_ready ? 1 : 0;
        gcnt++;
      end
    end
    @(posedge clk); #1;
    r0_valid = 1'b0; r1_valid = 1'b0;
    chk("cont_count", 32'(gcnt), 4);
    chk("cont_onehot", 32'(both), 0);
    for (int i = 0; i < 4; i++) begin
`ifdef LCD_ARB_RR_EN
      chk($sformatf("cont_grant%0d", i), 32'(gport[i]), 32'(i % 2));
`else
      chk($sformatf("cont_grant%0d", i), 32'(gport[i]), 0);
`endif
      if (i > 0) chk($sformatf("cont_gap%0d", i), 32'(gcyc[i] - gcyc[i-1]), 17);
    end
    for (int i = 0; i < 100 && busy; i++) @(negedge clk);
    chk("cont_drain", 32'(busy), 0);

    // Reset on the second lcd_e-high cycle.
    @(posedge clk); #1;
    r1_valid = 1'b1; r1_data = 8'h55; r1_rs = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (r1_ready) got = 1'b1;
    end
    @(posedge clk); #1;
    r1_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (lcd_e) got = 1'b1;
    end
    chk("mid_e_seen", 32'(got), 1);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("mid_lcd_e", 32'(lcd_e), 0);
    chk("mid_lcd_data", 32'(lcd_data), 0);
    chk("mid_busy", 32'(busy), 0);
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (busy || lcd_e) seen = 1'b1;
    end
    chk("mid_no_replay", 32'(seen), 0);
    send(1'b1, 8'h41, 1'b1, es, el, oc);
    chk("post_e_start", 32'(es), 3);
    chk("post_e_len", 32'(el), 4);
    chk("post_occ", 32'(oc), 17);
    chk("post_data", 32'(lcd_data), 32'h41);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
